load_rs_scheduler: RTL
======================

# load_rs_scheduler

Controller for the pool of load reservation-station entries in the Tomasulo core. It allocates entries in program order on issue and dispatches each entry's address to the single load unit through a valid/ready handshake. It tracks out-of-order memory responses and retires completed loads in order onto the CDB through a request/grant handshake. A flush clears all entries and discards stale in-flight responses.

## Interface
- DEPTH, 4, number of load entries; power of 2, ≥2
- IDX_W, log2(DEPTH), entry index width

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  squash all entries (branch mispredict)
- issue_valid  in  1  new load from issue stage
- issue_addr  in  32  effective address
- issue_mem_type  in  3  mem_u_b_h_w encoding, passed through
- issue_ready  out  1  entry available; issue accepted when issue_valid & issue_ready
- issue_idx  out  IDX_W  index the accepted load receives (tail pointer)
- mem_req_valid  out  1  dispatch request to load unit
- mem_req_ready  in  1  load unit accepts
- mem_req_addr  out  32  / mem_req_type  out  3  / mem_req_tag  out  IDX_W+1  {epoch, idx}
- mem_resp_valid  in  1  load data return (no backpressure)
- mem_resp_tag  in  IDX_W+1  tag of returning load
- mem_resp_data  in  32  load data
- cdb_req  out  1  head entry has data ready for broadcast
- cdb_grant  in  1  CDB arbiter took the result (FU_result_taken)
- cdb_idx  out  IDX_W  / cdb_data  out  32  result payload
- busy_vec  out  DEPTH  per-entry busy
- count  out  IDX_W+1  occupied entries

## Operation
- Per-entry state: FREE → WAIT (issued) → INFLIGHT (request accepted by load unit) → DONE (data held) → FREE (cdb_grant).
- Circular buffer: head (oldest), tail (next alloc), disp (next to dispatch); all wrap modulo DEPTH; count distinguishes full from empty.
- Issue accept: entry[tail] ← WAIT, with addr and type latched; tail++, count++.
- Dispatch: in order. mem_req_valid = (entry[disp] is WAIT). Payload comes from entry[disp], tag = {epoch, disp}. On valid & ready: entry → INFLIGHT, disp++. Valid and payload stay stable until ready.
- Response: accepted only when tag epoch == epoch and entry[idx] is INFLIGHT; entry → DONE, data latched. Otherwise silently dropped. Out-of-order returns are legal.
- Retire: cdb_req = (count≠0 & entry[head] DONE); cdb_idx = head, cdb_data = entry[head].data. On cdb_req & cdb_grant: entry → FREE, head++, count--. Grant without req is ignored.
- Flush: all entries FREE; head, tail and disp = 0; count = 0; epoch toggles. Flush has priority over issue, dispatch, response and grant in the same cycle. Latched data is not cleared.
- Constraint: the load unit returns or drops every request before a second flush, so a single epoch bit is sufficient.
- Simultaneous events:
  - Issue and grant in one cycle: both take effect; count unchanged.
  - issue_ready = (count < DEPTH) from registered state; a grant in the same cycle does not make a full buffer ready.
  - Response and dispatch in one cycle: both take effect.
  - Issue into an empty buffer while disp == tail: dispatch is visible the next cycle.

## Timing
- Reset (rst_n low, async): all entries FREE, head/tail/disp = 0, epoch = 0, count = 0.
  - Outputs during and after reset: issue_ready = 1, issue_idx = 0, mem_req_valid = 0, mem_req_addr = 0, mem_req_type = 0, mem_req_tag = 0, cdb_req = 0, cdb_idx = 0, cdb_data = 0, busy_vec = 0.
- Reset mid-operation clears everything at once. Responses arriving afterwards with epoch 0 for non-INFLIGHT entries are dropped.
- All outputs are combinational from registered state only; there is no input-to-output path.
- Issue accepted at edge N → mem_req_valid high from cycle N+1 (if entry is oldest WAIT).
- Response at edge M → cdb_req high from cycle M+1 (if head).
- Throughput: one issue, one dispatch, one response and one retire per cycle.
- Flush at edge F → cycle F+1 shows mem_req_valid = 0, cdb_req = 0, issue_ready = 1.

## Test plan
- Reset, then 4 issues (addr 0x100,0x104,0x108,0x10C; mem_req_ready=1) → issue_idx 0..3; issue_ready=0 after 4th; mem_req_tag 0..3 on consecutive cycles.
- mem_req_ready held 0 for 3 cycles → mem_req_valid, addr 0x100 and tag 0 stable; disp unchanged; accepted on 4th cycle.
- Responses tag 2, 0, 1 with data 0xA2, 0xA0, 0xA1 → cdb_req rises only after tag 0 returns; retire order idx 0,1,2 with matching data; count decrements per grant.
- Full buffer with issue_valid and cdb_grant in same cycle → issue not accepted; count = 3 next cycle; issue accepted the following cycle into idx 0.
- Two entries INFLIGHT, flush, new issue, then stale response {epoch 0, idx 0, 0xDEAD} → dropped; new entry stays INFLIGHT after dispatch; response {epoch 1, idx 0, 0xBEEF} → cdb_data = 0xBEEF.
- Flush and cdb_grant in same cycle; then rst_n pulsed low asynchronously mid-dispatch → all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/load_rs_scheduler.sv
// Load reservation-station pool: in-order allocate, in-order dispatch to the load unit,
// out-of-order response capture, in-order retire onto the CDB. Flush squashes via an epoch bit.
module load_rs_scheduler #(
   parameter int DEPTH = 4,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             issue_valid,
   input  logic [31:0]      issue_addr,
   input  logic [2:0]       issue_mem_type,
   output logic             issue_ready,
   output logic [IDX_W-1:0] issue_idx,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic [31:0]      mem_req_addr,
   output logic [2:0]       mem_req_type,
   output logic [IDX_W:0]   mem_req_tag,
   input  logic             mem_resp_valid,
   input  logic [IDX_W:0]   mem_resp_tag,
   input  logic [31:0]      mem_resp_data,
   output logic             cdb_req,
   input  logic             cdb_grant,
   output logic [IDX_W-1:0] cdb_idx,
   output logic [31:0]      cdb_data,
   output logic [DEPTH-1:0] busy_vec,
   output logic [IDX_W:0]   count
);

   typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_INFLIGHT, ST_DONE} state_t;

   localparam logic [IDX_W:0] LP_DEPTH = (IDX_W+1)'(DEPTH);

   logic [IDX_W-1:0] r_head, r_tail, r_disp;
   logic [IDX_W:0]   r_count;
   logic             r_epoch;

   logic [DEPTH-1:0][1:0]  w_state;
   logic [DEPTH-1:0][31:0] w_addr;
   logic [DEPTH-1:0][2:0]  w_type;
   logic [DEPTH-1:0][31:0] w_data;

   logic             w_issue_fire, w_disp_fire, w_resp_ok, w_retire;
   logic [IDX_W-1:0] w_resp_idx;

   assign issue_ready   = (r_count < LP_DEPTH);
   assign issue_idx     = r_tail;
   assign mem_req_valid = (w_state[r_disp] == ST_WAIT);
   assign mem_req_addr  = w_addr[r_disp];
   assign mem_req_type  = w_type[r_disp];
   assign mem_req_tag   = {r_epoch, r_disp};
   assign cdb_req       = (r_count != '0) && (w_state[r_head] == ST_DONE);
   assign cdb_idx       = r_head;
   assign cdb_data      = w_data[r_head];
   assign count         = r_count;

   assign w_issue_fire = issue_valid && issue_ready;
   assign w_disp_fire  = mem_req_valid && mem_req_ready;
   assign w_retire     = cdb_req && cdb_grant;
   assign w_resp_idx   = mem_resp_tag[IDX_W-1:0];
   // A response from before the last flush carries the old epoch and must not land.
   assign w_resp_ok    = mem_resp_valid && (mem_resp_tag[IDX_W] == r_epoch) &&
                         (w_state[w_resp_idx] == ST_INFLIGHT);

   // Issue/dispatch/response/retire always target entries in distinct states,
   // so each entry sees at most one transition per cycle.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         localparam logic [IDX_W-1:0] LP_IDX = IDX_W'(gi);
         state_t      r_state;
         logic [31:0] r_addr;
         logic [2:0]  r_type;
         logic [31:0] r_data;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_state <= ST_FREE;
               r_addr  <= '0;
               r_type  <= '0;
               r_data  <= '0;
            end else if (flush) begin
               r_state <= ST_FREE;
            end else begin
               if (w_issue_fire && (r_tail == LP_IDX)) begin
                  r_state <= ST_WAIT;
                  r_addr  <= issue_addr;
                  r_type  <= issue_mem_type;
               end
               if (w_disp_fire && (r_disp == LP_IDX))
                  r_state <= ST_INFLIGHT;
               if (w_resp_ok && (w_resp_idx == LP_IDX)) begin
                  r_state <= ST_DONE;
                  r_data  <= mem_resp_data;
               end
               if (w_retire && (r_head == LP_IDX))
                  r_state <= ST_FREE;
            end
         end

         assign w_state[gi]  = r_state;
         assign w_addr[gi]   = r_addr;
         assign w_type[gi]   = r_type;
         assign w_data[gi]   = r_data;
         assign busy_vec[gi] = (r_state != ST_FREE);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_disp  <= '0;
         r_count <= '0;
         r_epoch <= 1'b0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_disp  <= '0;
         r_count <= '0;
         r_epoch <= ~r_epoch;
      end else begin
         if (w_issue_fire) r_tail <= r_tail + 1'b1;
         if (w_disp_fire)  r_disp <= r_disp + 1'b1;
         if (w_retire)     r_head <= r_head + 1'b1;
         case ({w_issue_fire, w_retire})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
